// File: rtl/alu_pkg.sv
// ALU opcodes and default widths shared by the
// execute slice and the ALU-control unit.
package alu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 4;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_NOR   = 4'b0101;
  localparam logic [3:0] ALU_SLT   = 4'b0110;
  localparam logic [3:0] ALU_SLTU  = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_PASSB = 4'b1011;
  localparam logic [3:0] ALU_NOTA  = 4'b1100;

endpackage

// File: rtl/alu_writeback_unit_if.sv
// Operand/select inputs and registered results of
// the ALU writeback slice; slave = DUT side.
interface alu_writeback_unit_if
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
);

  logic [DATA_W-1:0] alu_input_a;
  logic [DATA_W-1:0] alu_input_b;
  logic [3:0]        alu_control;
  logic [DATA_W-1:0] extended_imm;
  logic              c_art_data;
  logic [REG_AW-1:0] dest_ar;
  logic [REG_AW-1:0] dest_t;
  logic              c_art_reg;
  logic [DATA_W-1:0] alu_output;
  logic              alu_cout;
  logic              alu_zero;
  logic [REG_AW-1:0] write_reg;
  logic [DATA_W-1:0] write_data;

  modport master (
    output alu_input_a, alu_input_b, alu_control,
    output extended_imm, c_art_data,
    output dest_ar, dest_t, c_art_reg,
    input  alu_output, alu_cout, alu_zero,
    input  write_reg, write_data
  );

  modport slave (
    input  alu_input_a, alu_input_b, alu_control,
    input  extended_imm, c_art_data,
    input  dest_ar, dest_t, c_art_reg,
    output alu_output, alu_cout, alu_zero,
    output write_reg, write_data
  );

endinterface

// File: rtl/alu_writeback_unit_mux2.sv
// Generic 2:1 select: y = sel ? b : a.
// Ports: sel, a, b (WIDTH), y (WIDTH).
module mux2 #(
  parameter int WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/alu_writeback_unit.sv
// Execute slice: 32-bit ALU, write-data/reg selects,
// one register stage. Ports: CLK, RESET (async low), bus.
module alu_writeback_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input logic CLK,
  input logic RESET,
  alu_writeback_unit_if.slave bus
);

  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] res;
  logic              cout;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] wd_sel;
  logic [REG_AW-1:0] wr_sel;

  assign a     = bus.alu_input_a;
  assign b     = bus.alu_input_b;
  assign shamt = b[4:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};

  always_comb begin
    res  = '0;
    cout = 1'b0;
    case (bus.alu_control)
      ALU_ADD: begin
        res  = sum[DATA_W-1:0];
        cout = sum[DATA_W];
      end
      ALU_SUB: begin
        res  = diff[DATA_W-1:0];
        // no borrow means a >= b unsigned
        cout = ~diff[DATA_W];
      end
      ALU_AND:   res = a & b;
      ALU_OR:    res = a | b;
      ALU_XOR:   res = a ^ b;
      ALU_NOR:   res = ~(a | b);
      ALU_SLT:
        res = {{(DATA_W-1){1'b0}},
               ($signed(a) < $signed(b))};
      ALU_SLTU:
        res = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_SLL:   res = a << shamt;
      ALU_SRL:   res = a >> shamt;
      ALU_SRA:   res = $signed(a) >>> shamt;
      ALU_PASSB: res = b;
      ALU_NOTA:  res = ~a;
      default: begin
        res  = '0;
        cout = 1'b0;
      end
    endcase
  end

  mux2 #(.WIDTH(DATA_W)) u_wd_mux (
    .sel (bus.c_art_data),
    .a   (res),
    .b   (bus.extended_imm),
    .y   (wd_sel)
  );

  mux2 #(.WIDTH(REG_AW)) u_wr_mux (
    .sel (bus.c_art_reg),
    .a   (bus.dest_ar),
    .b   (bus.dest_t),
    .y   (wr_sel)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bus.alu_output <= '0;
      bus.alu_cout   <= 1'b0;
      bus.alu_zero   <= 1'b0;
      bus.write_reg  <= '0;
      bus.write_data <= '0;
    end else begin
      bus.alu_output <= res;
      bus.alu_cout   <= cout;
      bus.alu_zero   <= (res == '0);
      bus.write_reg  <= wr_sel;
      bus.write_data <= wd_sel;
    end
  end

endmodule

// File: tb/tb_alu_writeback_unit.sv
// Directed bench for alu_writeback_unit: ALU ops,
// muxes, one-cycle latency, async reset.
module tb_alu_writeback_unit;

  logic CLK;
  logic RESET;
  int   errs;
  int   checks;
  logic [31:0] prev_out;

  alu_writeback_unit_if bus ();

  alu_writeback_unit dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".out"}, bus.alu_output, 32'h0);
    check({tag, ".cout"}, {31'h0, bus.alu_cout}, 32'h0);
    check({tag, ".zero"}, {31'h0, bus.alu_zero}, 32'h0);
    check({tag, ".wr"}, {28'h0, bus.write_reg}, 32'h0);
    check({tag, ".wd"}, bus.write_data, 32'h0);
  endtask

  // Drive one op, confirm old value holds until the
  // edge, then check everything one edge later.
  task automatic run(input string tag,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [3:0]  op,
                     input logic [31:0] imm,
                     input logic        cd,
                     input logic [3:0]  ar,
                     input logic [3:0]  t,
                     input logic        cr,
                     input logic [31:0] er,
                     input logic        ec);
    logic [31:0] ewd;
    logic [3:0]  ewr;
    ewd = cd ? imm : er;
    ewr = cr ? t : ar;
    bus.alu_input_a  = a;
    bus.alu_input_b  = b;
    bus.alu_control  = op;
    bus.extended_imm = imm;
    bus.c_art_data   = cd;
    bus.dest_ar      = ar;
    bus.dest_t       = t;
    bus.c_art_reg    = cr;
    @(negedge CLK);
    check({tag, ".hold"}, bus.alu_output, prev_out);
    @(posedge CLK);
    #1;
    check({tag, ".out"}, bus.alu_output, er);
    check({tag, ".cout"}, {31'h0, bus.alu_cout},
          {31'h0, ec});
    check({tag, ".zero"}, {31'h0, bus.alu_zero},
          {31'h0, (er == 32'h0)});
    check({tag, ".wd"}, bus.write_data, ewd);
    check({tag, ".wr"}, {28'h0, bus.write_reg},
          {28'h0, ewr});
    prev_out = er;
  endtask

  task automatic alu(input string tag,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [3:0]  op,
                     input logic [31:0] er,
                     input logic        ec);
    run(tag, a, b, op, 32'h0, 1'b0, 4'h0, 4'h0,
        1'b0, er, ec);
  endtask

  initial begin
    errs     = 0;
    checks   = 0;
    prev_out = 32'h0;
    RESET    = 1'b0;
    bus.alu_input_a  = $urandom;
    bus.alu_input_b  = $urandom;
    bus.alu_control  = 4'h0;
    bus.extended_imm = $urandom;
    bus.c_art_data   = 1'b1;
    bus.dest_ar      = 4'hA;
    bus.dest_t       = 4'h5;
    bus.c_art_reg    = 1'b1;
    #2;
    check_zero("rst_pre_edge");
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check_zero("rst_held");
    RESET = 1'b1;

    alu("add", 32'd5, 32'd3, 4'b0000, 32'd8, 1'b0);
    alu("sub", 32'd5, 32'd3, 4'b0001, 32'd2, 1'b1);
    alu("sub_neg", 32'd3, 32'd5, 4'b0001,
        32'hFFFFFFFE, 1'b0);
    alu("sub_eq", 32'd7, 32'd7, 4'b0001, 32'h0, 1'b1);
    alu("add_wrap", 32'hFFFFFFFF, 32'd1, 4'b0000,
        32'h0, 1'b1);
    alu("add_ovf", 32'h7FFFFFFF, 32'd1, 4'b0000,
        32'h80000000, 1'b0);
    alu("and", 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0010,
        32'h00F000F0, 1'b0);
    alu("or", 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0011,
        32'hFFF0FFF0, 1'b0);
    alu("xor", 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0100,
        32'hFF00FF00, 1'b0);
    alu("nor", 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0101,
        32'h000F000F, 1'b0);
    alu("slt", 32'hFFFFFFFF, 32'd1, 4'b0110,
        32'd1, 1'b0);
    alu("sltu", 32'hFFFFFFFF, 32'd1, 4'b0111,
        32'd0, 1'b0);
    alu("sra", 32'h80000000, 32'd4, 4'b1010,
        32'hF8000000, 1'b0);
    alu("srl", 32'h80000000, 32'd4, 4'b1001,
        32'h08000000, 1'b0);
    alu("sll", 32'h80000000, 32'd4, 4'b1000,
        32'h0, 1'b0);
    alu("sll_sh0", 32'h12345678, 32'h20, 4'b1000,
        32'h12345678, 1'b0);
    alu("srl_b40", 32'h80000001, 32'hFFFFFFE1, 4'b1001,
        32'h40000000, 1'b0);
    alu("passb", 32'd1, 32'hDEADBEEF, 4'b1011,
        32'hDEADBEEF, 1'b0);
    alu("nota", 32'h0000FFFF, 32'h0, 4'b1100,
        32'hFFFF0000, 1'b0);
    alu("op_d", 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1101,
        32'h0, 1'b0);
    alu("op_f", 32'd5, 32'd3, 4'b1111, 32'h0, 1'b0);

    run("wd_imm", 32'd5, 32'd3, 4'b0000, 32'hFFFC0000,
        1'b1, 4'hB, 4'h3, 1'b0, 32'd8, 1'b0);
    run("zero_imm", 32'hFFFFFFFF, 32'd1, 4'b0000,
        32'h1234, 1'b1, 4'hB, 4'h3, 1'b1, 32'h0, 1'b1);
    run("wr_ar", 32'd9, 32'd1, 4'b0001, 32'h0,
        1'b0, 4'hB, 4'h3, 1'b0, 32'd8, 1'b1);
    run("wr_t", 32'd9, 32'd1, 4'b0000, 32'h0,
        1'b0, 4'hB, 4'h3, 1'b1, 32'd10, 1'b0);

    // Mid-stream reset pulse between edges
    #2;
    RESET = 1'b0;
    #1;
    check_zero("rst_mid");
    @(posedge CLK);
    #1;
    check_zero("rst_mid_edge");
    RESET = 1'b1;
    #1;
    check_zero("rst_released");
    prev_out = 32'h0;
    run("post_rst", 32'd100, 32'd23, 4'b0001, 32'h0,
        1'b0, 4'h7, 4'h2, 1'b0, 32'd77, 1'b1);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/alu_writeback_unit.md
Name: alu_writeback_unit

Overview:
- Execute-stage datapath slice of the single-cycle processor.
- Contains a combinational 32-bit ALU driven by a 4-bit control code from the ALU-control unit.
- Contains a 2:1 write-data select (ALU result vs. sign-extended immediate) and a 2:1 write-register select (AR dest field vs. T dest field).
- Results are registered once and feed the register file write port.

Parameters:
- DATA_W, 32, datapath width; ALU operands, immediate and write data.
- REG_AW, 4, register-address width for both dest-field inputs and write_reg.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-low reset.
- alu_input_a  input  DATA_W  ALU operand A (register file read port 1).
- alu_input_b  input  DATA_W  ALU operand B (register file read port 2).
- alu_control  input  4  ALU operation code.
- extended_imm  input  DATA_W  sign-extended T-type constant.
- c_art_data  input  1  write-data select: 0 = ALU result, 1 = extended_imm.
- dest_ar  input  REG_AW  AR dest field, instr[14:11].
- dest_t  input  REG_AW  T dest field, instr[22:19].
- c_art_reg  input  1  write-register select: 0 = dest_ar, 1 = dest_t.
- alu_output  output  DATA_W  registered ALU result.
- alu_cout  output  1  registered carry flag.
- alu_zero  output  1  registered flag: ALU result == 0.
- write_reg  output  REG_AW  registered selected dest register.
- write_data  output  DATA_W  registered selected write data.

Behaviour:
- Clock and reset: one clock (CLK); reset is asynchronous and active-low (RESET). While RESET=0, all outputs are 0 immediately, independent of CLK. The first capture occurs on the first CLK rise after deassertion.
- Latency: every output updates on CLK rise with the values of that cycle's inputs. One-cycle latency, no stall, no handshake, a new operation every cycle.
- ALU, combinational, 32-bit, wrap-around arithmetic:
  - 0000 ADD: A+B; cout = carry out of bit 31.
  - 0001 SUB: A-B; cout = 1 when A >= B unsigned (no borrow).
  - 0010 AND. 0011 OR. 0100 XOR. 0101 NOR.
  - 0110 SLT: 1 if A < B signed, else 0.
  - 0111 SLTU: unsigned compare, same result format as SLT.
  - 1000 SLL: A << B[4:0].
  - 1001 SRL: A >> B[4:0], logical.
  - 1010 SRA: A >> B[4:0], arithmetic.
  - 1011 PASSB: result = B.
  - 1100 NOTA: result = ~A.
  - 1101..1111: result 0, cout 0.
  - cout is 0 for every op except ADD and SUB.
- Write-data mux: write_data = c_art_data ? extended_imm : alu_result. Selection uses this cycle's ALU result, not the previously registered one.
- Write-register mux: write_reg = c_art_reg ? dest_t : dest_ar.
- alu_zero reflects the ALU result only, independent of the write-data mux.
- Boundary conditions:
  - Shift amount 0 passes A unchanged; only B[4:0] is used.
  - 0x7FFFFFFF+1 gives 0x80000000 with cout=0.
  - 0xFFFFFFFF+1 gives 0 with cout=1 and zero=1.
  - X/Z on a select input is not supported; the bench drives only 0/1.
  - Reset asserted mid-stream clears outputs at once. Outputs stay 0 until the next CLK rise after RESET returns high.

Decomposition:
- Shared package alu_pkg holds the 4-bit ALU opcode localparams (ALU_ADD … ALU_NOTA) and DATA_W/REG_AW defaults. The ALU-control unit imports the same package.
- One sub-module: mux2 with a WIDTH parameter, instantiated at DATA_W for write data and REG_AW for write register.
- The ALU core is a combinational always block inside this module.
- The output register stage lives in the top.

Test Plan:
- Reset: hold RESET=0 with random inputs -> all outputs 0, including asynchronously before any CLK edge. Release -> first edge captures inputs.
- ADD/SUB: A=5, B=3, ctrl 0000 -> alu_output 8, cout 0. Ctrl 0001 -> 2, cout 1. A=3, B=5 SUB -> 0xFFFFFFFE, cout 0.
- Carry/zero: A=0xFFFFFFFF, B=1, ADD -> alu_output 0, cout 1, zero 1. A=0x7FFFFFFF, B=1 -> 0x80000000, cout 0.
- Logic/compare/shift:
  - A=0xF0F0F0F0, B=0x0FF00FF0 -> AND 0x00F000F0, OR 0xFFF0FFF0, XOR 0xFF00FF00, NOR 0x000F000F.
  - A=0xFFFFFFFF, B=1: SLT -> 1, SLTU -> 0.
  - A=0x80000000, B=4: SRA -> 0xF8000000, SRL -> 0x08000000, SLL -> 0.
- Mux selects:
  - c_art_data=0 -> write_data == ALU result.
  - c_art_data=1, extended_imm=0xFFFC0000 -> write_data 0xFFFC0000.
  - dest_ar=0xB, dest_t=0x3: c_art_reg=0 -> write_reg 0xB; c_art_reg=1 -> 0x3.
- Back-to-back and reset mid-stream: change ctrl/operands every cycle -> each result appears exactly one edge later. Pulse RESET low between edges -> outputs 0 immediately and until the next post-release edge.
